id_ex_operandos: RTL and testbench

- ID/EX pipeline stage sitting directly upstream of the EX-stage ALU.
- Registers one decoded instruction per clock from the decode stage.
- Resolves RAW data hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU operand inputs (entrada1, entrada2) and operation selector; supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/id_ex_operandos.sv | 135 +++++++++++++
 tb/tb_id_ex_operandos.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operandos.sv
// ID/EX stage feeding the ALU: one registered instruction, stall/flush control,
// and (with ID_EX_FORWARDING_EN defined) EX/MEM and MEM/WB operand bypass.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_*                            decoded instruction from the decode stage
//   stall, flush                    hazard-unit hold / bubble (flush wins)
//   exmem_*, memwb_*                forwarding sources (ignored if macro undefined)
//   ex_valido, entrada1, entrada2   EX slot valid and ALU operands
//   selector, ex_rd, ex_escribe_reg ALU op, destination, write-enable
module id_ex_operandos #(
  parameter int ANCHO    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valido,
  input  logic [ANCHO-1:0]    id_dato1,
  input  logic [ANCHO-1:0]    id_dato2,
  input  logic [ANCHO-1:0]    id_inmediato,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_usa_inm,
  input  logic [2:0]          id_selector,
  input  logic                id_escribe_reg,
  input  logic                stall,
  input  logic                flush,
  input  logic                exmem_escribe,
  input  logic [REG_BITS-1:0] exmem_rd,
  input  logic [ANCHO-1:0]    exmem_res,
  input  logic                memwb_escribe,
  input  logic [REG_BITS-1:0] memwb_rd,
  input  logic [ANCHO-1:0]    memwb_dato,
  output logic                ex_valido,
  output logic [ANCHO-1:0]    entrada1,
  output logic [ANCHO-1:0]    entrada2,
  output logic [2:0]          selector,
  output logic [REG_BITS-1:0] ex_rd,
  output logic                ex_escribe_reg
);

  logic                r_valido;
  logic [ANCHO-1:0]    r_dato1;
  logic [ANCHO-1:0]    r_dato2;
  logic [ANCHO-1:0]    r_inm;
  logic [REG_BITS-1:0] r_rs;
  logic [REG_BITS-1:0] r_rt;
  logic [REG_BITS-1:0] r_rd;
  logic                r_usa_inm;
  logic [2:0]          r_sel;
  logic                r_esc;

  logic [ANCHO-1:0]    w_opa;
  logic [ANCHO-1:0]    w_opb;

`ifdef ID_EX_FORWARDING_EN
  logic w_xa, w_ma, w_xb, w_mb;

  // EX/MEM is the newer producer, so it is checked first.
  assign w_xa = r_valido && exmem_escribe &&
                exmem_rd != '0 && exmem_rd == r_rs;
  assign w_ma = r_valido && memwb_escribe &&
                memwb_rd != '0 && memwb_rd == r_rs;
  assign w_xb = r_valido && exmem_escribe &&
                exmem_rd != '0 && exmem_rd == r_rt;
  assign w_mb = r_valido && memwb_escribe &&
                memwb_rd != '0 && memwb_rd == r_rt;

  always_comb begin
    w_opa = r_dato1;
    if (w_xa)      w_opa = exmem_res;
    else if (w_ma) w_opa = memwb_dato;
  end

  always_comb begin
    w_opb = r_dato2;
    if (w_xb)      w_opb = exmem_res;
    else if (w_mb) w_opb = memwb_dato;
  end
`else
  logic w_unused;

  assign w_opa    = r_dato1;
  assign w_opb    = r_dato2;
  assign w_unused = ^{exmem_escribe, exmem_rd, exmem_res,
                      memwb_escribe, memwb_rd, memwb_dato};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valido  <= 1'b0;
      r_dato1   <= '0;
      r_dato2   <= '0;
      r_inm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_usa_inm <= 1'b0;
      r_sel     <= 3'b000;
      r_esc     <= 1'b0;
    end else if (flush) begin
      // Zeroed rs/rt keep the bubble from ever matching a producer.
      r_valido <= 1'b0;
      r_esc    <= 1'b0;
      r_rs     <= '0;
      r_rt     <= '0;
    end else if (stall) begin
`ifdef ID_EX_FORWARDING_EN
      // Latch bypassed values so they survive the producer retiring.
      r_dato1 <= w_opa;
      r_dato2 <= w_opb;
`endif
    end else begin
      r_valido  <= id_valido;
      r_dato1   <= id_dato1;
      r_dato2   <= id_dato2;
      r_inm     <= id_inmediato;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_usa_inm <= id_usa_inm;
      r_sel     <= id_selector;
      r_esc     <= id_escribe_reg & id_valido;
    end
  end

  assign ex_valido      = r_valido;
  assign entrada1       = w_opa;
  assign entrada2       = r_usa_inm ? r_inm : w_opb;
  assign selector       = r_sel;
  assign ex_rd          = r_rd;
  assign ex_escribe_reg = r_esc;

endmodule

// File: tb/tb_id_ex_operandos.sv
// Scoreboard bench for id_ex_operandos: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_ex_operandos;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valido = 0;
  logic [31:0] id_dato1 = 0, id_dato2 = 0, id_inmediato = 0;
  logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
  logic        id_usa_inm = 0;
  logic [2:0]  id_selector = 0;
  logic        id_escribe_reg = 0;
  logic        stall = 0, flush = 0;
  logic        exmem_escribe = 0, memwb_escribe = 0;
  logic [4:0]  exmem_rd = 0, memwb_rd = 0;
  logic [31:0] exmem_res = 0, memwb_dato = 0;
  logic        ex_valido, ex_escribe_reg;
  logic [31:0] entrada1, entrada2;
  logic [2:0]  selector;
  logic [4:0]  ex_rd;

  id_ex_operandos dut (
    .clk(clk), .rst_n(rst_n),
    .id_valido(id_valido), .id_dato1(id_dato1),
    .id_dato2(id_dato2), .id_inmediato(id_inmediato),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_usa_inm(id_usa_inm), .id_selector(id_selector),
    .id_escribe_reg(id_escribe_reg),
    .stall(stall), .flush(flush),
    .exmem_escribe(exmem_escribe), .exmem_rd(exmem_rd),
    .exmem_res(exmem_res),
    .memwb_escribe(memwb_escribe), .memwb_rd(memwb_rd),
    .memwb_dato(memwb_dato),
    .ex_valido(ex_valido), .entrada1(entrada1),
    .entrada2(entrada2), .selector(selector),
    .ex_rd(ex_rd), .ex_escribe_reg(ex_escribe_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic        esc;
    bit          data;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".valido"}, 32'(ex_valido), 32'(e.v));
      chk({e.name, ".escribe"}, 32'(ex_escribe_reg), 32'(e.esc));
      if (e.data) begin
        chk({e.name, ".entrada1"}, entrada1, e.e1);
        chk({e.name, ".entrada2"}, entrada2, e.e2);
        chk({e.name, ".selector"}, 32'(selector), 32'(e.sel));
        chk({e.name, ".ex_rd"}, 32'(ex_rd), 32'(e.rd));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic put(string nm, logic v, logic [31:0] e1,
                     logic [31:0] e2, logic [2:0] sel,
                     logic [4:0] rd, logic esc, bit data);
    exp_t e;
    e.name = nm; e.v = v; e.e1 = e1; e.e2 = e2;
    e.sel = sel; e.rd = rd; e.esc = esc; e.data = data;
    q.push_back(e);
  endtask

  task automatic fwd(logic xe, logic [4:0] xrd, logic [31:0] xr,
                     logic me, logic [4:0] mrd, logic [31:0] md);
    exmem_escribe = xe; exmem_rd = xrd; exmem_res = xr;
    memwb_escribe = me; memwb_rd = mrd; memwb_dato = md;
  endtask

  task automatic ld(logic v, logic [31:0] d1, logic [31:0] d2,
                    logic [31:0] im, logic [4:0] rs, logic [4:0] rt,
                    logic [4:0] rd, logic usa, logic [2:0] sel,
                    logic esc);
    id_valido = v; id_dato1 = d1; id_dato2 = d2;
    id_inmediato = im; id_rs = rs; id_rt = rt; id_rd = rd;
    id_usa_inm = usa; id_selector = sel; id_escribe_reg = esc;
  endtask

  initial begin
    nxt();
    put("reset", 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    ld(1, 32'h5, 32'h7, 0, 1, 2, 9, 0, 3'b010, 1);

    nxt();
    fwd(0, 0, 0, 0, 0, 0);
    put("load", 1, 32'h5, 32'h7, 3'b010, 9, 1, 1);
    ld(1, 32'h11, 32'h22, 0, 3, 5, 4, 0, 3'b001, 1);

    nxt();
    fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
    put("fwd_exmem", 1, FWD ? 32'hAA : 32'h11, 32'h22,
        3'b001, 4, 1, 1);

    nxt();
    fwd(0, 3, 32'hAA, 1, 3, 32'hBB);
    put("fwd_memwb", 1, FWD ? 32'hBB : 32'h11, 32'h22,
        3'b001, 4, 1, 1);

    nxt();
    fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
    put("fwd_rd0", 1, 32'h11, 32'h22, 3'b001, 4, 1, 1);
    ld(1, 32'h33, 32'h44, 32'hFFFF_FFFC, 0, 6, 7, 1, 3'b010, 1);

    nxt();
    fwd(1, 6, 32'h55, 0, 0, 0);
    put("imm", 1, 32'h33, 32'hFFFF_FFFC, 3'b010, 7, 1, 1);
    ld(1, 32'h33, 32'h44, 32'hFFFF_FFFC, 0, 6, 7, 0, 3'b010, 1);

    nxt();
    fwd(1, 6, 32'h55, 0, 0, 0);
    put("fwd_opb", 1, 32'h33, FWD ? 32'h55 : 32'h44,
        3'b010, 7, 1, 1);
    ld(1, 32'h1, 32'h2, 0, 4, 0, 8, 0, 3'b110, 1);

    nxt();
    fwd(1, 4, 32'h1234, 0, 0, 0);
    put("stall_pre", 1, FWD ? 32'h1234 : 32'h1, 32'h2,
        3'b110, 8, 1, 1);
    stall = 1'b1;
    ld(1, 32'hDEAD, 32'hBEEF, 32'h9, 9, 9, 3, 1, 3'b000, 0);

    for (int i = 0; i < 3; i++) begin
      nxt();
      fwd(0, 4, 32'h1234, 0, 4, 32'h999);
      put("stall_hold", 1, FWD ? 32'h1234 : 32'h1, 32'h2,
          3'b110, 8, 1, 1);
    end
    flush = 1'b1;

    nxt();
    put("flush", 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b0;
    flush = 1'b0;
    ld(1, 32'h77, 32'h88, 0, 2, 3, 5, 0, 3'b111, 0);

    nxt();
    fwd(0, 0, 0, 0, 0, 0);
    put("reload", 1, 32'h77, 32'h88, 3'b111, 5, 0, 1);
    ld(0, 32'h99, 32'hAA, 0, 2, 3, 1, 0, 3'b000, 1);

    nxt();
    fwd(1, 2, 32'hEE, 1, 3, 32'hDD);
    put("bubble", 0, 32'h99, 32'hAA, 3'b000, 1, 0, 1);
    ld(1, 32'h42, 32'h43, 0, 1, 1, 6, 0, 3'b010, 1);

    nxt();
    fwd(0, 0, 0, 0, 0, 0);
    put("pre_rst", 1, 32'h42, 32'h43, 3'b010, 6, 1, 1);

    nxt();
    #1;
    rst_n = 1'b0;
    put("async_rst", 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
